// File: rtl/alu_zflag_datamem.sv
// Datapath execution slice: 8-op ALU with zero detect, a registered zero flag (one-cycle latency) and a 128x8 RAM.
// RAM reads are asynchronous and writes are synchronous; `define DATAMEM_CLEAR_EN to make reset clear the RAM.
module alu_zflag_datamem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op_alu,
  output logic [DATA_W-1:0] alu_y,
  output logic              alu_z,
  input  logic              wez,
  output logic              z,
  input  logic              mem_we,
  input  logic              mem_en,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wd,
  output logic [DATA_W-1:0] mem_rd
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    OP_PASS_A = 3'b000,
    OP_NOT_A  = 3'b001,
    OP_ADD    = 3'b010,
    OP_SUB    = 3'b011,
    OP_AND    = 3'b100,
    OP_OR     = 3'b101,
    OP_NEG_A  = 3'b110,
    OP_NEG_B  = 3'b111
  } alu_op_t;

  logic [DATA_W-1:0] mem [DEPTH];

  always_comb begin
    alu_y = '0;
    case (alu_op_t'(op_alu))
      OP_PASS_A: alu_y = a;
      OP_NOT_A:  alu_y = ~a;
      OP_ADD:    alu_y = a + b;
      OP_SUB:    alu_y = a - b;
      OP_AND:    alu_y = a & b;
      OP_OR:     alu_y = a | b;
      OP_NEG_A:  alu_y = '0 - a;
      OP_NEG_B:  alu_y = '0 - b;
      default:   alu_y = '0;
    endcase
  end

  assign alu_z = (alu_y == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      z <= 1'b0;
    end else if (wez) begin
      z <= alu_z;
    end
  end

`ifdef DATAMEM_CLEAR_EN
  // Reset wins over a same-cycle write so the RAM is guaranteed all-zero afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wd;
    end
  end
`else
  // Reset deliberately does not gate writes: RAM is independent of reset here.
  always_ff @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wd;
    end
  end
`endif

  assign mem_rd = mem_en ? mem[mem_addr] : '0;

endmodule

// File: tb/tb_alu_zflag_datamem.sv
// Bench for alu_zflag_datamem: directed vectors with literal expectations plus an
// arithmetic reference model checked every cycle.
module tb_alu_zflag_datamem;

  logic       clk;
  logic       reset;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op_alu;
  logic [7:0] alu_y;
  logic       alu_z;
  logic       wez;
  logic       z;
  logic       mem_we;
  logic       mem_en;
  logic [6:0] mem_addr;
  logic [7:0] mem_wd;
  logic [7:0] mem_rd;

  int errors = 0;
  int checks = 0;

  alu_zflag_datamem #(.DATA_W(8), .ADDR_W(7)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .op_alu(op_alu),
    .alu_y(alu_y), .alu_z(alu_z), .wez(wez), .z(z),
    .mem_we(mem_we), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Reference ALU in plain integer arithmetic modulo 256.
  function automatic int exp_y(input int op, input int av, input int bv);
    case (op)
      0: return av;
      1: return 255 - av;
      2: return (av + bv) % 256;
      3: return (av - bv + 256) % 256;
      4: return av & bv;
      5: return av | bv;
      6: return (256 - av) % 256;
      default: return (256 - bv) % 256;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Model state: -1 marks a RAM word never written (undefined contents).
  int model_mem [128];
  int model_z;
  bit model_z_known = 1'b0;
  bit model_run = 1'b0;

  initial begin
    for (int i = 0; i < 128; i++) model_mem[i] = -1;
  end

  always @(posedge clk) begin
    if (reset) begin
      model_z = 0;
      model_z_known = 1'b1;
    end else if (wez) begin
      model_z = (exp_y(int'(op_alu), int'(a), int'(b)) == 0) ? 1 : 0;
    end
`ifdef DATAMEM_CLEAR_EN
    if (reset) begin
      for (int i = 0; i < 128; i++) model_mem[i] = 0;
    end else if (mem_en && mem_we) begin
      model_mem[mem_addr] = int'(mem_wd);
    end
`else
    if (mem_en && mem_we) model_mem[mem_addr] = int'(mem_wd);
`endif
  end

  // Every-cycle comparison against the model, well after inputs settle.
  always begin
    @(negedge clk);
    #3;
    if (model_run) begin
      int ey;
      ey = exp_y(int'(op_alu), int'(a), int'(b));
      chk("model_alu_y", 32'(alu_y), 32'(ey));
      chk("model_alu_z", 32'(alu_z), (ey == 0) ? 32'd1 : 32'd0);
      if (model_z_known) chk("model_z", 32'(z), 32'(model_z));
      if (!mem_en) chk("model_mem_rd_dis", 32'(mem_rd), 32'd0);
      else if (model_mem[mem_addr] >= 0) chk("model_mem_rd", 32'(mem_rd), 32'(model_mem[mem_addr]));
    end
  end

  logic [7:0] sweep_exp [8];

  initial begin
    sweep_exp = '{8'h05, 8'hFA, 8'h08, 8'h02, 8'h01, 8'h07, 8'hFB, 8'hFD};
    reset = 1'b1; a = '0; b = '0; op_alu = '0; wez = 1'b0;
    mem_we = 1'b0; mem_en = 1'b0; mem_addr = '0; mem_wd = '0;
    repeat (2) @(negedge clk);
    model_run = 1'b1;
    reset = 1'b0;
    #2 chk("reset_z", 32'(z), 32'd0);

    // ALU sweep
    for (int op = 0; op < 8; op++) begin
      @(negedge clk);
      a = 8'h05; b = 8'h03; op_alu = 3'(op);
      #2;
      chk($sformatf("sweep_y_op%0d", op), 32'(alu_y), 32'(sweep_exp[op]));
      chk($sformatf("sweep_z_op%0d", op), 32'(alu_z), 32'd0);
    end

    // Zero flag capture, hold, update
    @(negedge clk);
    a = 8'h2A; b = 8'h2A; op_alu = 3'b011; wez = 1'b1;
    #2 chk("sub_equal_alu_z", 32'(alu_z), 32'd1);
    @(negedge clk);
    a = 8'h01; op_alu = 3'b000; wez = 1'b0;
    #2 chk("zflag_set", 32'(z), 32'd1);
    @(negedge clk);
    #2 chk("zflag_hold", 32'(z), 32'd1);
    wez = 1'b1;
    @(negedge clk);
    wez = 1'b0;
    #2 chk("zflag_clear", 32'(z), 32'd0);

    // Reset beats wez
    a = 8'h00; op_alu = 3'b000; wez = 1'b1;
    @(negedge clk);
    #2 chk("zflag_preset", 32'(z), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; wez = 1'b0;
    #2 chk("reset_priority_z", 32'(z), 32'd0);

    // RAM write and read
    mem_en = 1'b1; mem_we = 1'b1; mem_addr = 7'h10; mem_wd = 8'h5C;
    @(negedge clk);
    mem_addr = 7'h7F; mem_wd = 8'hA3;
    @(negedge clk);
    mem_we = 1'b0; mem_addr = 7'h10;
    #2 chk("ram_rd_10", 32'(mem_rd), 32'h5C);
    @(negedge clk);
    mem_addr = 7'h7F;
    #2 chk("ram_rd_7f", 32'(mem_rd), 32'hA3);
    @(negedge clk);
    mem_en = 1'b0;
    #2 chk("ram_rd_disabled", 32'(mem_rd), 32'h00);

    // Write gated by enable
    mem_we = 1'b1; mem_addr = 7'h10; mem_wd = 8'hFF;
    @(negedge clk);
    mem_en = 1'b1; mem_we = 1'b0;
    #2 chk("ram_write_gated", 32'(mem_rd), 32'h5C);

    // Read during write shows old data, then new
    @(negedge clk);
    mem_we = 1'b1; mem_wd = 8'h77;
    #2 chk("ram_rd_old_during_we", 32'(mem_rd), 32'h5C);
    @(negedge clk);
    mem_we = 1'b0;
    #2 chk("ram_rd_new_after_we", 32'(mem_rd), 32'h77);
    mem_we = 1'b1; mem_wd = 8'h5C;
    @(negedge clk);
    mem_we = 1'b0;

    // Reset vs RAM, including a write requested during reset
    reset = 1'b1; mem_en = 1'b1; mem_we = 1'b1; mem_addr = 7'h20; mem_wd = 8'h3C;
    @(negedge clk);
    reset = 1'b0; mem_we = 1'b0; mem_addr = 7'h10;
`ifdef DATAMEM_CLEAR_EN
    #2 chk("reset_ram_10", 32'(mem_rd), 32'h00);
    mem_addr = 7'h20;
    #1 chk("reset_write_20", 32'(mem_rd), 32'h00);
`else
    #2 chk("reset_ram_10", 32'(mem_rd), 32'h5C);
    mem_addr = 7'h20;
    #1 chk("reset_write_20", 32'(mem_rd), 32'h3C);
`endif

    // Flag load and RAM write in the same cycle
    @(negedge clk);
    a = 8'h00; op_alu = 3'b000; wez = 1'b1;
    mem_we = 1'b1; mem_addr = 7'h30; mem_wd = 8'h11;
    @(negedge clk);
    wez = 1'b0; mem_we = 1'b0; a = 8'h09;
    #2;
    chk("simul_z", 32'(z), 32'd1);
    chk("simul_mem", 32'(mem_rd), 32'h11);

    // Pseudo-random traffic checked only by the model
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      a = 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 3) == 0) ? a : 8'($urandom_range(0, 255));
      op_alu = 3'($urandom_range(0, 7));
      wez = 1'($urandom_range(0, 1));
      mem_en = ($urandom_range(0, 3) != 0);
      mem_we = 1'($urandom_range(0, 1));
      mem_addr = 7'($urandom_range(0, 15));
      mem_wd = 8'($urandom_range(0, 255));
      reset = ($urandom_range(0, 31) == 0);
    end
    @(negedge clk);
    reset = 1'b0; wez = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    #5;
    model_run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
